mul_seq_xnyn: RTL and testbench
===============================

# mul_seq_xnyn

Parametrised sequential shift-add multiplier, the next generation after the fixed-width combinational 2x2/3x3 unsigned and signed multiplier tops. It accepts X_WIDTH by Y_WIDTH operands under a start/ready handshake and supports unsigned or signed (two's complement) mode selected per operation. It produces a full-width product after a fixed number of cycles. It sits behind the same 8-in/8-out top-level pin wrapper as the earlier multipliers, with x, y, mode and start driven from io_in and p, s and rdy driven onto io_out.

## Interface
- X_WIDTH, 3: multiplicand width in bits; minimum 2.
- Y_WIDTH, 3: multiplier width in bits; minimum 2. Sets the iteration count.
- P_WIDTH, X_WIDTH+Y_WIDTH: product width. Fixed by derivation; not overridable.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; level-sampled on a rising edge, only in IDLE.
- sgn  in  1  mode: 0 = unsigned, 1 = signed two's complement. Captured with the operands.
- x  in  X_WIDTH  multiplicand. Captured at acceptance.
- y  in  Y_WIDTH  multiplier. Captured at acceptance.
- p  out  P_WIDTH  product register. Holds the last result until the next completion.
- s  out  1  result sign: p[P_WIDTH-1] in signed mode, 0 in unsigned mode.
- rdy  out  1  result valid. High from completion until the next accepted start.
- busy  out  1  high while an operation is in progress.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1; iteration counter runs 0..Y_WIDTH-1.
  - FIN: busy=1; a single cycle.
- Transitions:
  - IDLE -> RUN when start=1 at an edge.
  - RUN -> FIN when the counter equals Y_WIDTH-1.
  - FIN -> IDLE unconditionally.
- Acceptance edge:
  - Latch sgn.
  - Multiplicand register = |x| and multiplier register = |y|, magnitudes held unsigned. In unsigned mode these are x and y unchanged.
  - neg = sgn & (x[MSB] ^ y[MSB]).
  - Accumulator cleared; rdy cleared.
- RUN iteration: if the multiplier LSB is 1, add the multiplicand, shifted left by the counter value, into the P_WIDTH accumulator. Then shift the multiplier right by 1.
- FIN edge:
  - p = neg ? (two's-complement negation of accumulator) : accumulator.
  - s = sgn & p[P_WIDTH-1], computed from the new p.
  - rdy = 1; return to IDLE.
- The most negative operand is handled exactly: |-2^(n-1)| = 2^(n-1) fits n unsigned bits.
- A zero product always yields p=0 and s=0, even when neg=1.
- start, x, y and sgn are ignored while busy=1. Changes to the operands after acceptance do not affect the result.
- start held high: a new operation is accepted on the first edge after returning to IDLE. In that case rdy pulses for exactly 1 cycle.
- Reset assertion at any time, including mid-RUN, aborts the operation. No partial result reaches p.

## Timing
- Reset values: p=0, s=0, rdy=0, busy=0; state = IDLE; counter, accumulator and operand registers = 0.
- Latency: with start accepted at edge E0, RUN occupies edges E1..E(Y_WIDTH) and FIN occurs at edge E(Y_WIDTH+1). p, s and rdy update at E(Y_WIDTH+1); rdy rises after that edge.
  - For Y_WIDTH=3: rdy is high after E4.
- busy rises after E0 and falls after E(Y_WIDTH+1). rdy and busy are never both 1.
- Throughput: one result per Y_WIDTH+2 cycles with start held high.
- p and s are stable for the whole time rdy=1. All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Unsigned, defaults: x=7, y=7, sgn=0, one-cycle start -> after 4 edges p=6'b110001 (49), s=0, rdy=1, busy=0.
- Signed, most-negative operands: x=3'b100, y=3'b100, sgn=1 -> p=6'b010000 (+16), s=0.
- Signed, mixed signs: x=3'b101 (-3), y=3'b010 (2), sgn=1 -> p=6'b111010 (-6), s=1. Also x=-3, y=0 -> p=0, s=0.
- Start while busy: a second start with x=1, y=1 two cycles after the first 7*7 start -> ignored; p=49 and rdy exactly once. A fresh start while rdy=1 clears rdy after the acceptance edge.
- Reset mid-operation: drop rst after E2 of a 5*6 unsigned op -> p=0, rdy=0, busy=0 immediately. After rst releases, a new 5*6 op gives p=30.
- Parametrised sweep: X_WIDTH=4, Y_WIDTH=5, exhaustive x, y and sgn -> every p matches the reference product and every rdy arrives exactly 6 edges after acceptance.

Source files
------------

// File: rtl/mul_seq_xnyn.sv
// Sequential shift-add multiplier, X_WIDTH x Y_WIDTH operands,
// unsigned or two's-complement signed per operation.
module mul_seq_xnyn #(
    parameter  int X_WIDTH = 3,
    parameter  int Y_WIDTH = 3,
    localparam int P_WIDTH = X_WIDTH + Y_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    output logic [P_WIDTH-1:0] p,
    output logic               s,
    output logic               rdy,
    output logic               busy
);

    localparam int CW = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(Y_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      cnt;
    logic [X_WIDTH-1:0] mc;
    logic [Y_WIDTH-1:0] mp;
    logic [P_WIDTH-1:0] acc;
    logic               sg;
    logic               neg;
    logic [X_WIDTH-1:0] mag_x;
    logic [Y_WIDTH-1:0] mag_y;
    logic [P_WIDTH-1:0] p_n;

    // Magnitudes of the most negative value still fit as unsigned.
    always_comb begin
        mag_x = (sgn && x[X_WIDTH-1]) ? -x : x;
        mag_y = (sgn && y[Y_WIDTH-1]) ? -y : y;
        p_n   = neg ? -acc : acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            mc   <= '0;
            mp   <= '0;
            acc  <= '0;
            sg   <= 1'b0;
            neg  <= 1'b0;
            p    <= '0;
            s    <= 1'b0;
            rdy  <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sg   <= sgn;
                        mc   <= mag_x;
                        mp   <= mag_y;
                        neg  <= sgn & (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
                        acc  <= '0;
                        cnt  <= '0;
                        rdy  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (mp[0]) acc <= acc + (P_WIDTH'(mc) << cnt);
                    mp  <= mp >> 1;
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                FIN: begin
                    p    <= p_n;
                    s    <= sg & p_n[P_WIDTH-1];
                    rdy  <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_xnyn.sv
// Scoreboard bench for mul_seq_xnyn: default 3x3 instance with
// directed vectors and a 4x5 instance swept exhaustively.
module tb_mul_seq_xnyn;

    typedef struct {
        logic [15:0] p;
        logic        s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start = 1'b0;
    logic       sgn   = 1'b0;
    logic [2:0] x     = '0;
    logic [2:0] y     = '0;
    logic [5:0] p;
    logic       s;
    logic       rdy;
    logic       busy;

    logic       start2 = 1'b0;
    logic       sgn2   = 1'b0;
    logic [3:0] x2     = '0;
    logic [4:0] y2     = '0;
    logic [8:0] p2;
    logic       s2;
    logic       rdy2;
    logic       busy2;

    int   tests = 0;
    int   fails = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    mul_seq_xnyn dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sgn  (sgn),
        .x    (x),
        .y    (y),
        .p    (p),
        .s    (s),
        .rdy  (rdy),
        .busy (busy)
    );

    mul_seq_xnyn #(.X_WIDTH(4), .Y_WIDTH(5)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .start(start2),
        .sgn  (sgn2),
        .x    (x2),
        .y    (y2),
        .p    (p2),
        .s    (s2),
        .rdy  (rdy2),
        .busy (busy2)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Monitor for the 3x3 instance: pops on each rising rdy.
    initial begin : mon1
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy && busy) chk("rdy_busy_overlap", 16'd1, 16'd0);
            if (rdy && !prev) begin
                if (q1.size() == 0) begin
                    chk("unexpected_rdy", 16'd1, 16'd0);
                end else begin
                    e = q1.pop_front();
                    chk("p", 16'(p), e.p);
                    chk("s", 16'(s), 16'(e.s));
                end
            end
            prev = rdy;
        end
    end

    initial begin : mon2
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy2 && !prev) begin
                if (q2.size() == 0) begin
                    chk("unexpected_rdy2", 16'd1, 16'd0);
                end else begin
                    e = q2.pop_front();
                    chk("p2", 16'(p2), e.p);
                    chk("s2", 16'(s2), 16'(e.s));
                end
            end
            prev = rdy2;
        end
    end

    task automatic wait_rdy(input string nm, input int want);
        int n;
        n = 0;
        while (!rdy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 16'(n), 16'(want));
    endtask

    task automatic op1(input logic [2:0] xv, input logic [2:0] yv,
                       input logic sv, input logic [5:0] ep,
                       input logic es);
        @(negedge clk);
        x = xv;
        y = yv;
        sgn = sv;
        start = 1'b1;
        q1.push_back('{p: 16'(ep), s: es});
        @(posedge clk);
        #1;
        start = 1'b0;
        x = ~xv;
        y = ~yv;
        chk("busy_after_accept", 16'(busy), 16'd1);
        chk("rdy_cleared", 16'(rdy), 16'd0);
        wait_rdy("latency", 4);
    endtask

    task automatic op2(input logic [3:0] xv, input logic [4:0] yv,
                       input logic sv);
        int xi, yi, pr, n;
        logic [8:0] ep;
        xi = sv ? int'($signed(xv)) : int'(xv);
        yi = sv ? int'($signed(yv)) : int'(yv);
        pr = xi * yi;
        ep = pr[8:0];
        @(negedge clk);
        x2 = xv;
        y2 = yv;
        sgn2 = sv;
        start2 = 1'b1;
        q2.push_back('{p: 16'(ep), s: sv & ep[8]});
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0;
        while (!rdy2 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency2", 16'(n), 16'd6);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_p", 16'(p), 16'd0);
        chk("rst_s", 16'(s), 16'd0);
        chk("rst_rdy", 16'(rdy), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst = 1'b1;

        op1(3'd7, 3'd7, 1'b0, 6'b110001, 1'b0);
        op1(3'b100, 3'b100, 1'b1, 6'b010000, 1'b0);
        op1(3'b101, 3'b010, 1'b1, 6'b111010, 1'b1);
        op1(3'b101, 3'b000, 1'b1, 6'd0, 1'b0);
        op1(3'b011, 3'b111, 1'b1, 6'b111101, 1'b1);
        op1(3'd6, 3'd5, 1'b0, 6'd30, 1'b0);

        // Second start while busy must be ignored.
        @(negedge clk);
        x = 3'd7;
        y = 3'd7;
        sgn = 1'b0;
        start = 1'b1;
        q1.push_back('{p: 16'd49, s: 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        x = 3'd1;
        y = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("held_p_49", 16'(p), 16'd49);

        // Start held high: back-to-back ops, rdy one cycle wide.
        @(negedge clk);
        x = 3'd2;
        y = 3'd3;
        sgn = 1'b0;
        start = 1'b1;
        q1.push_back('{p: 16'd6, s: 1'b0});
        @(posedge clk);
        #1;
        x = 3'd3;
        y = 3'd3;
        q1.push_back('{p: 16'd9, s: 1'b0});
        wait_rdy("b2b_lat1", 4);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_rdy_pulse", 16'(rdy), 16'd0);
        chk("b2b_busy", 16'(busy), 16'd1);
        wait_rdy("b2b_lat2", 4);

        // Reset mid-operation aborts with no partial result.
        @(negedge clk);
        x = 3'd5;
        y = 3'd6;
        sgn = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_p", 16'(p), 16'd0);
        chk("abort_rdy", 16'(rdy), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        op1(3'd5, 3'd6, 1'b0, 6'd30, 1'b0);

        for (int sv = 0; sv < 2; sv++)
            for (int xv = 0; xv < 16; xv++)
                for (int yv = 0; yv < 32; yv++)
                    op2(4'(xv), 5'(yv), 1'(sv));

        repeat (5) @(negedge clk);
        chk("q1_drained", 16'(q1.size()), 16'd0);
        chk("q2_drained", 16'(q2.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
